tx_mailbox_scheduler: RTL and testbench

Transmit scheduler for the CAN channel unit. Shares the single bit-level transmitter between NUM_MB transmit mailboxes: waits for the bus-idle indication from the interframe detector, picks the pending mailbox with the highest CAN priority (lowest identifier), launches the frame, and retires, retries or aborts the mailbox based on the transmitter's outcome.

---
 rtl/tx_mailbox_scheduler_if.sv | 32 +++
 rtl/tx_mailbox_scheduler.sv | 154 +++++++++++++++
 tb/tb_tx_mailbox_scheduler.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/tx_mailbox_scheduler_if.sv
// Mailbox-side and transmitter-side signals of the CAN transmit scheduler.
// The scheduler connects through the slave modport. The master modport drives the mailboxes and transmitter.
interface tx_mailbox_scheduler_if #(
  parameter int NUM_MB = 4,
  parameter int ID_W   = 11
);
  logic                     enable;
  logic [NUM_MB-1:0]        mbReq;
  logic [NUM_MB*ID_W-1:0]   mbId;
  logic                     interframePeriod;
  logic                     bitTick;
  logic                     txDone;
  logic                     txError;
  logic                     txArbLost;
  logic                     txStart;
  logic [NUM_MB-1:0]        txGrant;
  logic [ID_W-1:0]          txId;
  logic [NUM_MB-1:0]        mbDone;
  logic [NUM_MB-1:0]        mbAbort;
  logic                     busy;
  logic [2:0]               schedState;

  modport master (
    output enable, mbReq, mbId, interframePeriod, bitTick, txDone, txError, txArbLost,
    input  txStart, txGrant, txId, mbDone, mbAbort, busy, schedState
  );

  modport slave (
    input  enable, mbReq, mbId, interframePeriod, bitTick, txDone, txError, txArbLost,
    output txStart, txGrant, txId, mbDone, mbAbort, busy, schedState
  );
endinterface

// File: rtl/tx_mailbox_scheduler.sv
// Shares one CAN bit transmitter between NUM_MB mailboxes. It launches the lowest-ID request at bus idle.
// It retires, retries or aborts that mailbox according to the transmitter outcome.
module tx_mailbox_scheduler #(
  parameter int NUM_MB    = 4,
  parameter int ID_W      = 11,
  parameter int MAX_RETRY = 8
) (
  input  logic                 clk,
  input  logic                 resetN,
  tx_mailbox_scheduler_if.slave bus
);

  localparam int             IDX_W       = $clog2(NUM_MB);
  localparam logic [3:0]     MAX_RETRY_C = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_BUS = 3'd1,
    S_SELECT   = 3'd2,
    S_LAUNCH   = 3'd3,
    S_ACTIVE   = 3'd4,
    S_RELEASE  = 3'd5
  } state_t;

  state_t            state, state_nxt;

  logic              win_vld;
  logic [IDX_W-1:0]  win_idx;
  logic [ID_W-1:0]   win_id;
  logic [NUM_MB-1:0] win_onehot;

  logic [IDX_W-1:0]  grant_idx;
  logic [3:0]        retry [NUM_MB];
  logic [3:0]        retry_inc;
  logic              abort_hit;

  logic              tx_start_r;
  logic [NUM_MB-1:0] tx_grant_r;
  logic [ID_W-1:0]   tx_id_r;
  logic [NUM_MB-1:0] mb_done_r;
  logic [NUM_MB-1:0] mb_abort_r;

  // Strict less-than keeps the lower index when identifiers tie
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    win_id  = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (bus.mbReq[i] && (!win_vld || (bus.mbId[i*ID_W +: ID_W] < win_id))) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(i);
        win_id  = bus.mbId[i*ID_W +: ID_W];
      end
    end
  end

  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

  assign retry_inc = (retry[grant_idx] == 4'hF) ? 4'hF : retry[grant_idx] + 4'd1;
  assign abort_hit = (MAX_RETRY != 0) && (retry_inc == MAX_RETRY_C);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.enable && (|bus.mbReq)) state_nxt = S_WAIT_BUS;
      end
      S_WAIT_BUS: begin
        if (!bus.enable || (bus.mbReq == '0))          state_nxt = S_IDLE;
        else if (bus.interframePeriod && bus.bitTick)  state_nxt = S_SELECT;
      end
      S_SELECT:  state_nxt = win_vld ? S_LAUNCH : S_IDLE;
      S_LAUNCH:  state_nxt = S_ACTIVE;
      S_ACTIVE: begin
        if (bus.txDone || bus.txError || bus.txArbLost) state_nxt = S_RELEASE;
      end
      S_RELEASE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs and per-mailbox retry bookkeeping
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      tx_start_r <= 1'b0;
      tx_grant_r <= '0;
      tx_id_r    <= '0;
      mb_done_r  <= '0;
      mb_abort_r <= '0;
      grant_idx  <= '0;
      for (int i = 0; i < NUM_MB; i++) retry[i] <= 4'd0;
    end else begin
      tx_start_r <= 1'b0;
      mb_done_r  <= '0;
      mb_abort_r <= '0;
      case (state)
        S_IDLE: begin
          for (int i = 0; i < NUM_MB; i++) begin
            if (!bus.mbReq[i]) retry[i] <= 4'd0;
          end
        end
        S_SELECT: begin
          if (win_vld) begin
            tx_grant_r <= win_onehot;
            tx_id_r    <= win_id;
            grant_idx  <= win_idx;
            tx_start_r <= 1'b1;
          end else begin
            tx_grant_r <= '0;
            tx_id_r    <= '0;
          end
        end
        S_ACTIVE: begin
          if (bus.txDone) begin
            mb_done_r[grant_idx] <= 1'b1;
            retry[grant_idx]     <= 4'd0;
          end else if (bus.txError) begin
            if (abort_hit) begin
              mb_abort_r[grant_idx] <= 1'b1;
              retry[grant_idx]      <= 4'd0;
            end else begin
              retry[grant_idx] <= retry_inc;
            end
          end
        end
        S_RELEASE: begin
          tx_grant_r <= '0;
          tx_id_r    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.txStart    = tx_start_r;
  assign bus.txGrant    = tx_grant_r;
  assign bus.txId       = tx_id_r;
  assign bus.mbDone     = mb_done_r;
  assign bus.mbAbort    = mb_abort_r;
  assign bus.busy       = (state != S_IDLE);
  assign bus.schedState = state;

endmodule

// File: tb/tb_tx_mailbox_scheduler.sv
// Directed bench for tx_mailbox_scheduler: a per-cycle vector table plus scripted retry, enable and reset sequences.
module tb_tx_mailbox_scheduler;

  localparam int NUM_MB = 4;
  localparam int ID_W   = 11;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  int   errors = 0;
  int   checks = 0;

  tx_mailbox_scheduler_if #(.NUM_MB(NUM_MB), .ID_W(ID_W)) bus ();

  tx_mailbox_scheduler #(.NUM_MB(NUM_MB), .ID_W(ID_W), .MAX_RETRY(3)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  localparam logic [43:0] IDS_A = {11'h000, 11'h000, 11'h000, 11'h123};
  localparam logic [43:0] IDS_B = {11'h7FF, 11'h050, 11'h050, 11'h300};

  typedef struct {
    logic        en;
    logic [3:0]  req;
    logic [43:0] ids;
    logic        ifp, tick, done, err, arb;
    logic        start;
    logic [3:0]  grant;
    logic [10:0] id;
    logic [3:0]  mdone, mabort;
    logic [2:0]  st;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic en, input logic [3:0] req, input logic [43:0] ids,
                              input logic ifp, input logic tick, input logic done,
                              input logic err, input logic arb, input logic start,
                              input logic [3:0] grant, input logic [10:0] id,
                              input logic [3:0] mdone, input logic [3:0] mabort,
                              input logic [2:0] st);
    vec_t v;
    v.en = en; v.req = req; v.ids = ids; v.ifp = ifp; v.tick = tick;
    v.done = done; v.err = err; v.arb = arb; v.start = start; v.grant = grant;
    v.id = id; v.mdone = mdone; v.mabort = mabort; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (bus.schedState !== s && n < budget) begin
      step();
      n++;
    end
    chk(name, 32'(bus.schedState), 32'(s));
  endtask

  task automatic launch(input logic [3:0] g, input string tag);
    wait_state(3'd1, 8, {tag, ".wait_bus"});
    bus.bitTick = 1'b1;
    step();
    bus.bitTick = 1'b0;
    chk({tag, ".select"}, 32'(bus.schedState), 32'd2);
    step();
    chk({tag, ".txStart"}, 32'(bus.txStart), 32'd1);
    chk({tag, ".txGrant"}, 32'(bus.txGrant), 32'(g));
    step();
    chk({tag, ".active"}, 32'(bus.schedState), 32'd4);
    chk({tag, ".txStart_low"}, 32'(bus.txStart), 32'd0);
  endtask

  task automatic finish_frame(input logic d, input logic e, input logic a,
                              input logic [3:0] exp_done, input logic [3:0] exp_abort,
                              input string tag);
    bus.txDone = d; bus.txError = e; bus.txArbLost = a;
    step();
    bus.txDone = 1'b0; bus.txError = 1'b0; bus.txArbLost = 1'b0;
    chk({tag, ".release"}, 32'(bus.schedState), 32'd5);
    chk({tag, ".mbDone"},  32'(bus.mbDone),  32'(exp_done));
    chk({tag, ".mbAbort"}, 32'(bus.mbAbort), 32'(exp_abort));
    step();
    chk({tag, ".idle"},        32'(bus.schedState), 32'd0);
    chk({tag, ".mbDone_low"},  32'(bus.mbDone),  32'd0);
    chk({tag, ".mbAbort_low"}, 32'(bus.mbAbort), 32'd0);
    chk({tag, ".grant_low"},   32'(bus.txGrant), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  initial begin
    bus.enable = 1'b0; bus.mbReq = '0; bus.mbId = '0; bus.interframePeriod = 1'b0;
    bus.bitTick = 1'b0; bus.txDone = 1'b0; bus.txError = 1'b0; bus.txArbLost = 1'b0;

    // columns: en req ids ifp tick done err arb | start grant id mbDone mbAbort state
    vq.push_back(mk(1, 4'b0001, IDS_A, 1, 0, 0, 0, 0,  0, 4'b0000, 11'h000, 4'b0000, 4'b0000, 3'd0));
    vq.push_back(mk(1, 4'b0001, IDS_A, 1, 1, 0, 0, 0,  0, 4'b0000, 11'h000, 4'b0000, 4'b0000, 3'd1));
    vq.push_back(mk(1, 4'b0001, IDS_A, 1, 0, 0, 0, 0,  0, 4'b0000, 11'h000, 4'b0000, 4'b0000, 3'd2));
    vq.push_back(mk(1, 4'b0001, IDS_A, 1, 0, 0, 0, 0,  1, 4'b0001, 11'h123, 4'b0000, 4'b0000, 3'd3));
    vq.push_back(mk(1, 4'b0001, IDS_A, 1, 0, 1, 0, 0,  0, 4'b0001, 11'h123, 4'b0000, 4'b0000, 3'd4));
    vq.push_back(mk(1, 4'b0000, IDS_A, 1, 0, 0, 0, 0,  0, 4'b0001, 11'h123, 4'b0001, 4'b0000, 3'd5));
    vq.push_back(mk(1, 4'b1111, IDS_B, 1, 0, 0, 0, 0,  0, 4'b0000, 11'h000, 4'b0000, 4'b0000, 3'd0));
    vq.push_back(mk(1, 4'b1111, IDS_B, 1, 1, 0, 0, 0,  0, 4'b0000, 11'h000, 4'b0000, 4'b0000, 3'd1));
    vq.push_back(mk(1, 4'b1111, IDS_B, 1, 0, 0, 0, 0,  0, 4'b0000, 11'h000, 4'b0000, 4'b0000, 3'd2));
    vq.push_back(mk(1, 4'b1111, IDS_B, 1, 0, 0, 0, 0,  1, 4'b0010, 11'h050, 4'b0000, 4'b0000, 3'd3));
    vq.push_back(mk(1, 4'b1111, IDS_B, 1, 0, 1, 0, 0,  0, 4'b0010, 11'h050, 4'b0000, 4'b0000, 3'd4));
    vq.push_back(mk(1, 4'b1101, IDS_B, 1, 0, 0, 0, 0,  0, 4'b0010, 11'h050, 4'b0010, 4'b0000, 3'd5));
    vq.push_back(mk(1, 4'b1101, IDS_B, 1, 0, 0, 0, 0,  0, 4'b0000, 11'h000, 4'b0000, 4'b0000, 3'd0));
    vq.push_back(mk(1, 4'b1101, IDS_B, 1, 1, 0, 0, 0,  0, 4'b0000, 11'h000, 4'b0000, 4'b0000, 3'd1));
    vq.push_back(mk(1, 4'b1101, IDS_B, 1, 0, 0, 0, 0,  0, 4'b0000, 11'h000, 4'b0000, 4'b0000, 3'd2));
    vq.push_back(mk(1, 4'b1101, IDS_B, 1, 0, 0, 0, 0,  1, 4'b0100, 11'h050, 4'b0000, 4'b0000, 3'd3));
    vq.push_back(mk(1, 4'b1101, IDS_B, 1, 0, 1, 1, 0,  0, 4'b0100, 11'h050, 4'b0000, 4'b0000, 3'd4));
    vq.push_back(mk(1, 4'b0000, IDS_B, 1, 0, 0, 0, 0,  0, 4'b0100, 11'h050, 4'b0100, 4'b0000, 3'd5));
    vq.push_back(mk(1, 4'b0001, IDS_A, 0, 1, 0, 0, 0,  0, 4'b0000, 11'h000, 4'b0000, 4'b0000, 3'd0));
    vq.push_back(mk(1, 4'b0001, IDS_A, 0, 1, 0, 0, 0,  0, 4'b0000, 11'h000, 4'b0000, 4'b0000, 3'd1));
    vq.push_back(mk(1, 4'b0001, IDS_A, 0, 1, 0, 0, 0,  0, 4'b0000, 11'h000, 4'b0000, 4'b0000, 3'd1));
    vq.push_back(mk(0, 4'b0001, IDS_A, 0, 1, 0, 0, 0,  0, 4'b0000, 11'h000, 4'b0000, 4'b0000, 3'd1));
    vq.push_back(mk(0, 4'b0001, IDS_A, 1, 1, 0, 0, 0,  0, 4'b0000, 11'h000, 4'b0000, 4'b0000, 3'd0));
    vq.push_back(mk(0, 4'b0001, IDS_A, 1, 1, 0, 0, 0,  0, 4'b0000, 11'h000, 4'b0000, 4'b0000, 3'd0));

    repeat (3) step();
    chk("reset.state",   32'(bus.schedState), 32'd0);
    chk("reset.busy",    32'(bus.busy),       32'd0);
    chk("reset.txGrant", 32'(bus.txGrant),    32'd0);
    chk("reset.txStart", 32'(bus.txStart),    32'd0);
    resetN = 1'b1;
    step();

    for (int k = 0; k < vq.size(); k++) begin
      bus.enable = vq[k].en; bus.mbReq = vq[k].req; bus.mbId = vq[k].ids;
      bus.interframePeriod = vq[k].ifp; bus.bitTick = vq[k].tick;
      bus.txDone = vq[k].done; bus.txError = vq[k].err; bus.txArbLost = vq[k].arb;
      #1;
      chk($sformatf("v%0d.txStart", k), 32'(bus.txStart),    32'(vq[k].start));
      chk($sformatf("v%0d.txGrant", k), 32'(bus.txGrant),    32'(vq[k].grant));
      chk($sformatf("v%0d.txId", k),    32'(bus.txId),       32'(vq[k].id));
      chk($sformatf("v%0d.mbDone", k),  32'(bus.mbDone),     32'(vq[k].mdone));
      chk($sformatf("v%0d.mbAbort", k), 32'(bus.mbAbort),    32'(vq[k].mabort));
      chk($sformatf("v%0d.state", k),   32'(bus.schedState), 32'(vq[k].st));
      chk($sformatf("v%0d.busy", k),    32'(bus.busy),       32'(vq[k].st != 3'd0));
      step();
    end

    // Retry / abort with MAX_RETRY = 3; arbitration loss does not count
    bus.enable = 1'b1; bus.interframePeriod = 1'b1; bus.bitTick = 1'b0;
    bus.txDone = 1'b0; bus.txError = 1'b0; bus.txArbLost = 1'b0;
    bus.mbReq = 4'b0001; bus.mbId = IDS_A;
    launch(4'b0001, "r1"); finish_frame(0, 1, 0, 4'b0000, 4'b0000, "r1.err");
    launch(4'b0001, "r2"); finish_frame(0, 0, 1, 4'b0000, 4'b0000, "r2.arb");
    launch(4'b0001, "r3"); finish_frame(0, 1, 0, 4'b0000, 4'b0000, "r3.err");
    launch(4'b0001, "r4"); finish_frame(0, 1, 0, 4'b0000, 4'b0001, "r4.abort");
    launch(4'b0001, "r5"); finish_frame(0, 1, 0, 4'b0000, 4'b0000, "r5.err");
    launch(4'b0001, "r6"); finish_frame(0, 1, 0, 4'b0000, 4'b0000, "r6.err");
    launch(4'b0001, "r7"); finish_frame(1, 1, 0, 4'b0001, 4'b0000, "r7.done_err");
    launch(4'b0001, "r8"); finish_frame(0, 1, 0, 4'b0000, 4'b0000, "r8.err");
    launch(4'b0001, "r9"); finish_frame(0, 1, 0, 4'b0000, 4'b0000, "r9.err");
    launch(4'b0001, "r10"); finish_frame(0, 1, 0, 4'b0000, 4'b0001, "r10.abort");

    // Enable drops mid-frame: frame still completes, nothing new launches
    launch(4'b0001, "en");
    bus.enable = 1'b0;
    step(); chk("en.hold_active", 32'(bus.schedState), 32'd4);
    step(); chk("en.hold_grant",  32'(bus.txGrant),    32'b0001);
    finish_frame(1, 0, 0, 4'b0001, 4'b0000, "en.done");
    bus.bitTick = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("en.off%0d.state", k),   32'(bus.schedState), 32'd0);
      chk($sformatf("en.off%0d.txStart", k), 32'(bus.txStart),    32'd0);
    end
    bus.bitTick = 1'b0;
    bus.enable = 1'b1;

    // Asynchronous reset during an active frame
    launch(4'b0001, "rst");
    resetN = 1'b0;
    #1;
    chk("rst.state",   32'(bus.schedState), 32'd0);
    chk("rst.busy",    32'(bus.busy),       32'd0);
    chk("rst.txGrant", 32'(bus.txGrant),    32'd0);
    chk("rst.txId",    32'(bus.txId),       32'd0);
    bus.txDone = 1'b1;
    step();
    bus.txDone = 1'b0;
    chk("rst.mbDone",  32'(bus.mbDone),     32'd0);
    chk("rst.mbAbort", 32'(bus.mbAbort),    32'd0);
    resetN = 1'b1;
    launch(4'b0001, "post");
    chk("post.txId", 32'(bus.txId), 32'h123);
    finish_frame(1, 0, 0, 4'b0001, 4'b0000, "post.done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
